// File: rtl/bft_pkg.sv
// Shared BFT definitions: default field widths, packet field offsets as
// functions of the widths, the credit counter type and the output-stage
// state encoding.
package bft_pkg;

   localparam int DEF_PACKET_BITS   = 97;
   localparam int DEF_NUM_LEAF_BITS = 6;
   localparam int DEF_NUM_PORT_BITS = 4;
   localparam int DEF_NUM_ADDR_BITS = 7;
   localparam int DEF_PAYLOAD_BITS  = 64;

   // Credit range is 0..DEPTH, hence one bit wider than the address.
   typedef logic [DEF_NUM_ADDR_BITS:0] credit_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } port_state_t;

   // Packet layout (MSB first): {vld, leaf, port, pad, addr, payload}
   function automatic int vld_bit(input int packet_bits);
      return packet_bits - 1;
   endfunction

   function automatic int leaf_lsb(input int packet_bits, input int leaf_bits);
      return packet_bits - 1 - leaf_bits;
   endfunction

   function automatic int port_lsb(input int packet_bits, input int leaf_bits,
                                   input int port_bits);
      return packet_bits - 1 - leaf_bits - port_bits;
   endfunction

   function automatic int addr_lsb(input int payload_bits);
      return payload_bits;
   endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter for the remote input-port BRAM.
//   clk, reset : clock, synchronous active-high reset (count <= MAX)
//   inc        : add STEP credits (freespace update received)
//   dec        : consume one credit (beat accepted); ignored at zero
//   count      : current credit value, 0..MAX
//   zero       : count == 0
//   ovf        : the update at this edge would exceed MAX and saturates
module credit_counter
   import bft_pkg::*;
#(
   parameter int CNT_BITS = DEF_NUM_ADDR_BITS + 1,
   parameter int MAX      = 2 ** DEF_NUM_ADDR_BITS,
   parameter int STEP     = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inc,
   input  logic                dec,
   output logic [CNT_BITS-1:0] count,
   output logic                zero,
   output logic                ovf
);

   localparam int SW = CNT_BITS + 1;

   logic [SW-1:0]       sum;
   logic [CNT_BITS-1:0] next_count;

   assign zero = (count == {CNT_BITS{1'b0}});

   // Combined increment/decrement in one update, then saturate at MAX.
   always_comb begin
      sum        = {1'b0, count};
      next_count = count;
      if (inc) begin
         sum = sum + SW'(STEP);
      end else begin
         sum = sum;
      end
      if (dec && !zero) begin
         sum = sum - {{(SW-1){1'b0}}, 1'b1};
      end else begin
         sum = sum;
      end
      ovf = (sum > SW'(MAX));
      if (ovf) begin
         next_count = CNT_BITS'(MAX);
      end else begin
         next_count = sum[CNT_BITS-1:0];
      end
   end

   // Credit register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= CNT_BITS'(MAX);
      end else begin
         count <= next_count;
      end
   end

endmodule

// File: rtl/output_port.sv
// BFT output port: packs user beats into BFT packets, holds them in a
// one-entry output register until the leaf arbiter grants, and throttles
// the user with a credit counter mirroring free space in the remote
// input-port BRAM.
//   clk, reset      : clock, synchronous active-high reset
//   dst_leaf/port   : destination, quasi-static
//   din_user2b_out  : user payload, vld_user2b_out its valid
//   ack_b_out2user  : beat accepted when vld & ack (combinational)
//   packet_out      : packet to arbiter, MSB = valid
//   grant_bft2out   : arbiter consumed packet_out this cycle
//   din_freespace   : freespace-update packet from the leaf
//   credit_err      : sticky credit overflow flag
// Optional feature macro: OUTPUT_PORT_CREDIT_CHECK_EN enables credit_err
// (otherwise tied low; saturation itself is always present).
module output_port
   import bft_pkg::*;
#(
   parameter int PACKET_BITS           = DEF_PACKET_BITS,
   parameter int NUM_LEAF_BITS         = DEF_NUM_LEAF_BITS,
   parameter int NUM_PORT_BITS         = DEF_NUM_PORT_BITS,
   parameter int NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS,
   parameter int PAYLOAD_BITS          = DEF_PAYLOAD_BITS,
   parameter int PORT_No               = 2,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
   input  logic [NUM_PORT_BITS-1:0] dst_port,
   input  logic [PAYLOAD_BITS-1:0]  din_user2b_out,
   input  logic                     vld_user2b_out,
   output logic                     ack_b_out2user,
   output logic [PACKET_BITS-1:0]   packet_out,
   input  logic                     grant_bft2out,
   input  logic [PACKET_BITS-1:0]   din_freespace,
   output logic                     credit_err
);

   localparam int VLD_BIT  = vld_bit(PACKET_BITS);
   localparam int LEAF_LSB = leaf_lsb(PACKET_BITS, NUM_LEAF_BITS);
   localparam int PORT_LSB = port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
   localparam int ADDR_LSB = addr_lsb(PAYLOAD_BITS);
   localparam int PAD_BITS = PORT_LSB - ADDR_LSB - NUM_ADDR_BITS;
   localparam int DEPTH    = 2 ** NUM_ADDR_BITS;

   port_state_t              state;
   logic [NUM_ADDR_BITS-1:0] wr_addr;
   logic [NUM_ADDR_BITS:0]   credit;
   logic                     credit_zero;
   logic                     credit_ovf;
   logic                     full;
   logic                     accept;
   logic                     fs_hit;
   logic                     fs_unused;

   assign full   = (state == ST_FULL);
   // Ack never looks at vld, so the user may use it to launch a beat.
   assign ack_b_out2user = !reset && !credit_zero && (!full || grant_bft2out);
   assign accept = vld_user2b_out && ack_b_out2user;
   assign fs_hit = din_freespace[VLD_BIT] &&
                   (din_freespace[PORT_LSB +: NUM_PORT_BITS] ==
                    NUM_PORT_BITS'(PORT_No));
   // Fields of the update packet that this port does not look at.
   assign fs_unused = ^{din_freespace[VLD_BIT-1:LEAF_LSB],
                        din_freespace[PORT_LSB-1:0]};

   credit_counter #(
      .CNT_BITS (NUM_ADDR_BITS + 1),
      .MAX      (DEPTH),
      .STEP     (FREESPACE_UPDATE_SIZE)
   ) u_credit (
      .clk   (clk),
      .reset (reset),
      .inc   (fs_hit),
      .dec   (accept),
      .count (credit),
      .zero  (credit_zero),
      .ovf   (credit_ovf)
   );

   // Output-stage FSM with registered packet and write address.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_EMPTY;
         packet_out <= {PACKET_BITS{1'b0}};
         wr_addr    <= {NUM_ADDR_BITS{1'b0}};
      end else begin
         if (accept) begin
            packet_out <= {1'b1, dst_leaf, dst_port, {PAD_BITS{1'b0}},
                           wr_addr, din_user2b_out};
            wr_addr    <= wr_addr + {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};
         end
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state <= ST_FULL;
               end
            end
            ST_FULL: begin
               // A load in the grant cycle simply overwrites the register.
               if (grant_bft2out && !accept) begin
                  state      <= ST_EMPTY;
                  packet_out <= {PACKET_BITS{1'b0}};
               end
            end
            default: begin
               state      <= ST_EMPTY;
               packet_out <= {PACKET_BITS{1'b0}};
            end
         endcase
      end
   end

`ifdef OUTPUT_PORT_CREDIT_CHECK_EN
   // Sticky flag for a credit update that had to saturate.
   always_ff @(posedge clk) begin
      if (reset) begin
         credit_err <= 1'b0;
      end else if (credit_ovf) begin
         credit_err <= 1'b1;
         $error("output_port: credit overflow, saturated at %0d", DEPTH);
      end else begin
         credit_err <= credit_err;
      end
   end
`else
   logic ovf_unused;
   assign ovf_unused = credit_ovf;
   assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_port.sv
// Self-checking bench for output_port with a scoreboard of expected packets
// and an independent credit/occupancy model.
module tb_output_port;

   localparam int PB = 97;

`ifdef OUTPUT_PORT_CREDIT_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [5:0]    dst_leaf = 6'd5;
   logic [3:0]    dst_port = 4'd9;
   logic [63:0]   din = 64'd0;
   logic          vld = 1'b0;
   logic          ack;
   logic [PB-1:0] packet_out;
   logic          grant = 1'b0;
   logic [PB-1:0] din_fs = '0;
   logic          credit_err;

   output_port dut (
      .clk            (clk),
      .reset          (reset),
      .dst_leaf       (dst_leaf),
      .dst_port       (dst_port),
      .din_user2b_out (din),
      .vld_user2b_out (vld),
      .ack_b_out2user (ack),
      .packet_out     (packet_out),
      .grant_bft2out  (grant),
      .din_freespace  (din_fs),
      .credit_err     (credit_err)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   int            n_acc = 0;
   int            n_pop = 0;
   int            m_credit = 128;
   bit            m_full = 1'b0;
   bit            m_err = 1'b0;
   logic [6:0]    m_addr = 7'd0;
   logic [63:0]   seq = 64'h1000;
   logic [PB-1:0] sb[$];
   logic [PB-1:0] held;

   task automatic check_eq(input string tag, input logic [PB-1:0] got,
                           input logic [PB-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [PB-1:0] fs_pkt(input bit v, input logic [3:0] port);
      return {v, 6'd0, port, 86'd0};
   endfunction

   // One clock cycle: inputs are already set; check at negedge, update model.
   task automatic step();
      bit exp_ack, acc, hit;
      int nc;
      logic [PB-1:0] exp_pkt;
      @(negedge clk);
      exp_ack = !reset && (m_credit != 0) && (!m_full || grant);
      check_eq("ack", ack, exp_ack);
      check_eq("full", packet_out[PB-1], m_full);
      check_eq("credit_err", credit_err, m_err);
      if (!reset && vld && ack) n_acc++;
      if (!reset && packet_out[PB-1] && grant) begin
         n_pop++;
         if (sb.size() == 0) begin
            check_eq("sb_empty", packet_out, '0);
         end else begin
            exp_pkt = sb.pop_front();
            check_eq("packet", packet_out, exp_pkt);
         end
      end
      if (reset) begin
         m_credit = 128; m_addr = 7'd0; m_full = 1'b0; m_err = 1'b0;
         sb.delete();
      end else begin
         acc = vld && exp_ack;
         hit = din_fs[PB-1] && (din_fs[89:86] == 4'd2);
         if (acc) begin
            sb.push_back({1'b1, dst_leaf, dst_port, 15'd0, m_addr, din});
            m_addr = m_addr + 7'd1;
            seq = seq + 64'd1;
         end
         nc = m_credit + (hit ? 64 : 0) - (acc ? 1 : 0);
         if (nc > 128) begin
            nc = 128;
            if (CHECK_EN) m_err = 1'b1;
         end
         m_credit = nc;
         if (acc) m_full = 1'b1;
         else if (grant) m_full = 1'b0;
      end
      @(posedge clk);
      #1;
      din = seq ^ 64'hA5A5_0000_0000_0000;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      din = seq ^ 64'hA5A5_0000_0000_0000;
      @(posedge clk);
      #1;
      run(2);
      check_eq("rst_pkt", packet_out, '0);
      reset = 1'b0;

      // 1: drain all 128 credits at full rate
      vld = 1'b1; grant = 1'b1; n_pop = 0;
      run(129);
      check_eq("t1_ack0", ack, 1'b0);
      check_eq("t1_count", n_pop, 128);

      // 2: one freespace update restores 64 credits, addresses wrap to 0
      din_fs = fs_pkt(1'b1, 4'd2);
      step();
      din_fs = '0;
      check_eq("t2_ack1", ack, 1'b1);
      n_pop = 0;
      run(70);
      check_eq("t2_count", n_pop, 64);

      // 3: updates for another port or with valid clear are ignored
      din_fs = fs_pkt(1'b1, 4'd3);
      step();
      din_fs = fs_pkt(1'b0, 4'd2);
      step();
      din_fs = '0;
      run(3);
      check_eq("t3_ack0", ack, 1'b0);
      check_eq("t3_err", credit_err, 1'b0);

      // 4: back-pressure holds the packet; a grant pulse drains and reloads
      vld = 1'b0;
      din_fs = fs_pkt(1'b1, 4'd2);
      step();
      din_fs = '0;
      vld = 1'b1; grant = 1'b0;
      step();
      held = packet_out;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("t4_hold", packet_out, held);
      end
      grant = 1'b1;
      step();
      grant = 1'b0;
      check_eq("t4_reload", packet_out[PB-1], 1'b1);
      step();
      vld = 1'b0; grant = 1'b1;
      step();

      // 5a: accept and update together at credit 10 -> 73
      vld = 1'b1;
      for (int i = 0; i < 200 && m_credit != 10; i++) step();
      check_eq("t5_reach10", m_credit, 10);
      din_fs = fs_pkt(1'b1, 4'd2);
      step();
      din_fs = '0;
      n_acc = 0;
      run(80);
      check_eq("t5_count73", n_acc, 73);

      // 5b: over-full update saturates at 128
      vld = 1'b0;
      din_fs = fs_pkt(1'b1, 4'd2);
      run(3);
      din_fs = '0;
      step();
      check_eq("t5_err", credit_err, CHECK_EN);
      vld = 1'b1; n_acc = 0;
      run(140);
      check_eq("t5_count128", n_acc, 128);

      // 6: reset while a packet is held
      vld = 1'b0;
      din_fs = fs_pkt(1'b1, 4'd2);
      step();
      din_fs = '0;
      vld = 1'b1; grant = 1'b0;
      run(2);
      check_eq("t6_held", packet_out[PB-1], 1'b1);
      reset = 1'b1; vld = 1'b0;
      step();
      reset = 1'b0;
      check_eq("t6_pkt", packet_out, '0);
      check_eq("t6_err", credit_err, 1'b0);
      vld = 1'b1; grant = 1'b1; n_acc = 0;
      run(132);
      check_eq("t6_count", n_acc, 128);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
